// File: rtl/csr_regfile_pkg.sv
// csr_regfile_pkg: CSR addresses, interrupt codes, mstatus bit positions and
// the input/output port-group types shared by the CSR storage block.
package csr_regfile_pkg;
    localparam logic [11:0] csr_mstatus   = 12'h300;
    localparam logic [11:0] csr_misa      = 12'h301;
    localparam logic [11:0] csr_mie       = 12'h304;
    localparam logic [11:0] csr_mtvec     = 12'h305;
    localparam logic [11:0] csr_mscratch  = 12'h340;
    localparam logic [11:0] csr_mepc      = 12'h341;
    localparam logic [11:0] csr_mcause    = 12'h342;
    localparam logic [11:0] csr_mtval     = 12'h343;
    localparam logic [11:0] csr_mip       = 12'h344;
    localparam logic [11:0] csr_mcycle    = 12'hB00;
    localparam logic [11:0] csr_minstret  = 12'hB02;
    localparam logic [11:0] csr_mcycleh   = 12'hB80;
    localparam logic [11:0] csr_minstreth = 12'hB82;
    localparam logic [11:0] csr_cycle     = 12'hC00;
    localparam logic [11:0] csr_instret   = 12'hC02;
    localparam logic [11:0] csr_cycleh    = 12'hC80;
    localparam logic [11:0] csr_instreth  = 12'hC82;
    localparam logic [11:0] csr_mhartid   = 12'hF14;

    localparam logic [4:0] irq_code_mei = 5'd11;
    localparam logic [4:0] irq_code_msi = 5'd3;
    localparam logic [4:0] irq_code_mti = 5'd7;

    localparam int mstatus_mie  = 3;
    localparam int mstatus_mpie = 7;
    localparam logic [31:0] mie_mask = 32'h0000_0888;

    typedef struct packed {
        logic [11:0] raddr;
        logic        wren;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic        exc;
        logic [31:0] exc_cause;
        logic [31:0] exc_epc;
        logic [31:0] exc_tval;
        logic        mret;
        logic        inst_ret;
        logic        mtip;
        logic        msip;
        logic        meip;
    } csr_regfile_in_type;

    typedef struct packed {
        logic [31:0] rdata;
        logic        rillegal;
        logic        willegal;
        logic        irq;
        logic [31:0] irq_cause;
        logic [31:0] trap_pc;
        logic [31:0] mepc_out;
    } csr_regfile_out_type;

    function automatic logic csr_known(input logic [11:0] a);
        return a inside {csr_mstatus, csr_misa, csr_mie, csr_mtvec, csr_mscratch,
                         csr_mepc, csr_mcause, csr_mtval, csr_mip, csr_mcycle,
                         csr_minstret, csr_mcycleh, csr_minstreth, csr_cycle,
                         csr_instret, csr_cycleh, csr_instreth, csr_mhartid};
    endfunction
endpackage

// File: rtl/csr_regfile_if.sv
// csr_regfile_if: read, commit, trap and interrupt signals between the core
// (master) and the CSR storage block (slave).
interface csr_regfile_if;
    logic [11:0] raddr;
    logic [31:0] rdata;
    logic        rillegal;
    logic        wren;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        willegal;
    logic        exc;
    logic [31:0] exc_cause;
    logic [31:0] exc_epc;
    logic [31:0] exc_tval;
    logic        mret;
    logic        inst_ret;
    logic        mtip;
    logic        msip;
    logic        meip;
    logic        irq;
    logic [31:0] irq_cause;
    logic [31:0] trap_pc;
    logic [31:0] mepc_out;

    modport master (
        output raddr, wren, waddr, wdata, exc, exc_cause, exc_epc, exc_tval,
               mret, inst_ret, mtip, msip, meip,
        input  rdata, rillegal, willegal, irq, irq_cause, trap_pc, mepc_out
    );

    modport slave (
        input  raddr, wren, waddr, wdata, exc, exc_cause, exc_epc, exc_tval,
               mret, inst_ret, mtip, msip, meip,
        output rdata, rillegal, willegal, irq, irq_cause, trap_pc, mepc_out
    );
endinterface

// File: rtl/csr_regfile_counter64.sv
// csr_counter64: 64-bit counter; a write to either half replaces that
// cycle's increment of the whole counter and leaves the other half alone.
module csr_counter64 (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_inc,
    input  logic        i_wr_lo,
    input  logic        i_wr_hi,
    input  logic [31:0] i_wdata,
    output logic [63:0] o_value
);
    logic [63:0] r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_count <= '0;
        else if (i_wr_lo) r_count[31:0] <= i_wdata;
        else if (i_wr_hi) r_count[63:32] <= i_wdata;
        else if (i_inc) r_count <= r_count + 64'd1;
    end

    assign o_value = r_count;
endmodule

// File: rtl/csr_regfile.sv
// csr_regfile: machine-mode CSR storage with trap/MRET state, cycle and
// instret counters, and interrupt-pending evaluation for the redirect logic.
module csr_regfile
    import csr_regfile_pkg::*;
#(
    parameter logic [31:0] HARTID   = 32'd0,
    parameter logic [31:0] MISA_VAL = 32'h4000_1100
) (
    input logic          clock,
    input logic          reset,
    csr_regfile_if.slave bus
);
    csr_regfile_in_type  w_in;
    csr_regfile_out_type w_out;

    logic        r_mstatus_mie, r_mstatus_mpie;
    logic [31:0] r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
    logic [31:0] w_mstatus, w_mip, w_pending, w_base, w_rdata, w_irq_cause, w_trap_pc;
    logic [63:0] w_mcycle, w_minstret;
    logic [4:0]  w_irq_code;
    logic        w_rillegal, w_willegal, w_wr, w_irq;

    assign w_in = '{raddr: bus.raddr, wren: bus.wren, waddr: bus.waddr, wdata: bus.wdata,
                    exc: bus.exc, exc_cause: bus.exc_cause, exc_epc: bus.exc_epc,
                    exc_tval: bus.exc_tval, mret: bus.mret, inst_ret: bus.inst_ret,
                    mtip: bus.mtip, msip: bus.msip, meip: bus.meip};

    // MPP is hardwired to machine mode; only MIE and MPIE are stored.
    assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};
    assign w_mip     = {20'b0, w_in.meip, 3'b0, w_in.mtip, 3'b0, w_in.msip, 3'b0};

    always_comb begin
        w_rdata = '0;
        case (w_in.raddr)
            csr_mstatus:              w_rdata = w_mstatus;
            csr_misa:                 w_rdata = MISA_VAL;
            csr_mie:                  w_rdata = r_mie;
            csr_mtvec:                w_rdata = r_mtvec;
            csr_mscratch:             w_rdata = r_mscratch;
            csr_mepc:                 w_rdata = r_mepc;
            csr_mcause:               w_rdata = r_mcause;
            csr_mtval:                w_rdata = r_mtval;
            csr_mip:                  w_rdata = w_mip;
            csr_mhartid:              w_rdata = HARTID;
            csr_mcycle, csr_cycle:    w_rdata = w_mcycle[31:0];
            csr_mcycleh, csr_cycleh:  w_rdata = w_mcycle[63:32];
            csr_minstret, csr_instret:    w_rdata = w_minstret[31:0];
            csr_minstreth, csr_instreth:  w_rdata = w_minstret[63:32];
            default:                  w_rdata = '0;
        endcase
    end

    assign w_rillegal = !csr_known(w_in.raddr);
    assign w_willegal = w_in.wren && (!csr_known(w_in.waddr) || w_in.waddr[11:10] == 2'b11);
    assign w_wr       = w_in.wren && !w_willegal && !w_in.exc && !w_in.mret;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= '0;
            r_mtvec        <= '0;
            r_mscratch     <= '0;
            r_mepc         <= '0;
            r_mcause       <= '0;
            r_mtval        <= '0;
        end else if (w_in.exc) begin
            r_mepc         <= {w_in.exc_epc[31:2], 2'b00};
            r_mcause       <= w_in.exc_cause;
            r_mtval        <= w_in.exc_tval;
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
        end else if (w_in.mret) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
        end else if (w_wr) begin
            case (w_in.waddr)
                csr_mstatus: begin
                    r_mstatus_mie  <= w_in.wdata[mstatus_mie];
                    r_mstatus_mpie <= w_in.wdata[mstatus_mpie];
                end
                csr_mie:      r_mie      <= w_in.wdata & mie_mask;
                csr_mtvec:    r_mtvec    <= w_in.wdata;
                csr_mscratch: r_mscratch <= w_in.wdata;
                csr_mepc:     r_mepc     <= {w_in.wdata[31:2], 2'b00};
                csr_mcause:   r_mcause   <= w_in.wdata;
                csr_mtval:    r_mtval    <= w_in.wdata;
                default: ;
            endcase
        end
    end

    csr_counter64 u_mcycle (
        .clock   (clock),
        .reset   (reset),
        .i_inc   (1'b1),
        .i_wr_lo (w_wr && w_in.waddr == csr_mcycle),
        .i_wr_hi (w_wr && w_in.waddr == csr_mcycleh),
        .i_wdata (w_in.wdata),
        .o_value (w_mcycle)
    );

    csr_counter64 u_minstret (
        .clock   (clock),
        .reset   (reset),
        .i_inc   (w_in.inst_ret),
        .i_wr_lo (w_wr && w_in.waddr == csr_minstret),
        .i_wr_hi (w_wr && w_in.waddr == csr_minstreth),
        .i_wdata (w_in.wdata),
        .o_value (w_minstret)
    );

    // Fixed priority MEI > MSI > MTI; the code equals the mip bit index.
    assign w_pending   = w_mip & r_mie;
    assign w_irq       = r_mstatus_mie && (w_pending != '0);
    assign w_irq_code  = w_pending[irq_code_mei] ? irq_code_mei :
                         w_pending[irq_code_msi] ? irq_code_msi : irq_code_mti;
    assign w_irq_cause = w_irq ? {1'b1, 26'b0, w_irq_code} : '0;

    assign w_base    = {r_mtvec[31:2], 2'b00};
    assign w_trap_pc = (r_mtvec[1:0] == 2'd1 && w_in.exc_cause[31]) ?
                       w_base + {25'b0, w_in.exc_cause[4:0], 2'b00} : w_base;

    assign w_out = '{rdata: w_rdata, rillegal: w_rillegal, willegal: w_willegal, irq: w_irq,
                     irq_cause: w_irq_cause, trap_pc: w_trap_pc, mepc_out: r_mepc};

    assign bus.rdata     = w_out.rdata;
    assign bus.rillegal  = w_out.rillegal;
    assign bus.willegal  = w_out.willegal;
    assign bus.irq       = w_out.irq;
    assign bus.irq_cause = w_out.irq_cause;
    assign bus.trap_pc   = w_out.trap_pc;
    assign bus.mepc_out  = w_out.mepc_out;
endmodule

// File: tb/tb_csr_regfile.sv
// tb_csr_regfile: directed and random stimulus against an architectural CSR
// model; expected outputs are queued and checked by a separate monitor.
module tb_csr_regfile;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clock = ~clock;

    csr_regfile_if bus ();

    csr_regfile dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [11:0] raddr;
        logic        wren;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic        exc;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] tval;
        logic        mret;
        logic        inst_ret;
        logic        mtip;
        logic        msip;
        logic        meip;
    } tx_t;

    typedef struct {
        logic [31:0] rdata;
        logic        rill;
        logic        will;
        logic        irq;
        logic [31:0] cause;
        logic [31:0] tpc;
        logic [31:0] mepc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    logic [31:0] st [logic [11:0]];
    logic        m_mie_b, m_mpie_b;
    logic [63:0] m_cyc, m_ins;

    logic [11:0] addr_list [20] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                    12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02, 12'hB80,
                                    12'hB82, 12'hC00, 12'hC02, 12'hC80, 12'hC82, 12'hF14,
                                    12'h7C0, 12'h000};
    logic [11:0] plain_regs [6] = '{12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343};

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", nm, got, want, $time);
        end
    endtask

    function automatic void m_reset();
        st.delete();
        foreach (plain_regs[i]) st[plain_regs[i]] = 32'h0;
        m_mie_b = 1'b0;
        m_mpie_b = 1'b0;
        m_cyc = 64'h0;
        m_ins = 64'h0;
    endfunction

    function automatic logic m_known(input logic [11:0] a);
        return st.exists(a) || a inside {12'h300, 12'h301, 12'h344, 12'hF14, 12'hB00, 12'hB02,
                                         12'hB80, 12'hB82, 12'hC00, 12'hC02, 12'hC80, 12'hC82};
    endfunction

    function automatic logic [31:0] m_mip(input tx_t t);
        return (32'(t.meip) << 11) | (32'(t.mtip) << 7) | (32'(t.msip) << 3);
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a, input tx_t t);
        if (st.exists(a)) return st[a];
        case (a)
            12'h300: return 32'h1800 | (32'(m_mpie_b) << 7) | (32'(m_mie_b) << 3);
            12'h301: return 32'h4000_1100;
            12'h344: return m_mip(t);
            12'hB00, 12'hC00: return m_cyc[31:0];
            12'hB80, 12'hC80: return m_cyc[63:32];
            12'hB02, 12'hC02: return m_ins[31:0];
            12'hB82, 12'hC82: return m_ins[63:32];
            default: return 32'h0;
        endcase
    endfunction

    function automatic exp_t m_expect(input tx_t t);
        exp_t e;
        logic [31:0] pend, mt, base;
        e.rdata = m_read(t.raddr, t);
        e.rill = !m_known(t.raddr);
        e.will = t.wren && (!m_known(t.waddr) || t.waddr >= 12'hC00);
        pend = m_mip(t) & st[12'h304];
        e.irq = m_mie_b && pend != 0;
        e.cause = !e.irq ? 32'h0 : pend[11] ? 32'h8000000B : pend[3] ? 32'h80000003 : 32'h80000007;
        mt = st[12'h305];
        base = mt & ~32'd3;
        e.tpc = (mt % 4 == 1 && t.cause[31]) ? base + 32'(t.cause[4:0]) * 4 : base;
        e.mepc = st[12'h341];
        return e;
    endfunction

    function automatic void m_update(input tx_t t);
        logic [63:0] nc, ni;
        logic [11:0] a;
        nc = m_cyc + 1;
        ni = m_ins + 64'(t.inst_ret);
        a = t.waddr;
        if (t.exc) begin
            st[12'h341] = t.epc & ~32'd3;
            st[12'h342] = t.cause;
            st[12'h343] = t.tval;
            m_mpie_b = m_mie_b;
            m_mie_b = 1'b0;
        end else if (t.mret) begin
            m_mie_b = m_mpie_b;
            m_mpie_b = 1'b1;
        end else if (t.wren && m_known(a) && a < 12'hC00) begin
            if (st.exists(a))
                st[a] = a == 12'h304 ? t.wdata & 32'h888 : a == 12'h341 ? t.wdata & ~32'd3 : t.wdata;
            else case (a)
                12'h300: begin m_mie_b = t.wdata[3]; m_mpie_b = t.wdata[7]; end
                12'hB00: nc = {m_cyc[63:32], t.wdata};
                12'hB80: nc = {t.wdata, m_cyc[31:0]};
                12'hB02: ni = {m_ins[63:32], t.wdata};
                12'hB82: ni = {t.wdata, m_ins[31:0]};
                default: ;
            endcase
        end
        m_cyc = nc;
        m_ins = ni;
    endfunction

    function automatic tx_t rd(input logic [11:0] a);
        tx_t t = '{default: '0};
        t.raddr = a;
        return t;
    endfunction

    function automatic tx_t wr(input logic [11:0] a, input logic [31:0] d);
        tx_t t = rd(a);
        t.wren = 1'b1;
        t.waddr = a;
        t.wdata = d;
        return t;
    endfunction

    function automatic tx_t rnd();
        tx_t t;
        t.raddr = addr_list[$urandom_range(0, 19)];
        t.wren = 1'($urandom % 2);
        t.waddr = addr_list[$urandom_range(0, 19)];
        t.wdata = ($urandom % 4 == 0) ? 32'hFFFF_FFFF : $urandom;
        t.exc = ($urandom % 8 == 0);
        t.cause = ($urandom % 2 == 1) ? (32'h8000_0000 | ($urandom % 16)) : ($urandom % 16);
        t.epc = $urandom;
        t.tval = $urandom;
        t.mret = ($urandom % 8 == 0);
        t.inst_ret = 1'($urandom % 2);
        t.mtip = 1'($urandom % 2);
        t.msip = 1'($urandom % 2);
        t.meip = 1'($urandom % 2);
        return t;
    endfunction

    task automatic drive(input tx_t t);
        bus.raddr = t.raddr;
        bus.wren = t.wren;
        bus.waddr = t.waddr;
        bus.wdata = t.wdata;
        bus.exc = t.exc;
        bus.exc_cause = t.cause;
        bus.exc_epc = t.epc;
        bus.exc_tval = t.tval;
        bus.mret = t.mret;
        bus.inst_ret = t.inst_ret;
        bus.mtip = t.mtip;
        bus.msip = t.msip;
        bus.meip = t.meip;
    endtask

    // sel picks an optional directed check: 0 rdata, 1 irq_cause, 2 trap_pc,
    // 3 willegal, 4 rillegal, 5 irq.
    task automatic step(input tx_t t, input int sel = -1, input logic [31:0] want = 0,
                        input string nm = "");
        drive(t);
        q.push_back(m_expect(t));
        @(negedge clock);
        case (sel)
            0: chk(nm, bus.rdata, want);
            1: chk(nm, bus.irq_cause, want);
            2: chk(nm, bus.trap_pc, want);
            3: chk(nm, 32'(bus.willegal), want);
            4: chk(nm, 32'(bus.rillegal), want);
            5: chk(nm, 32'(bus.irq), want);
            default: ;
        endcase
        @(posedge clock);
        m_update(t);
        #1;
    endtask

    always @(negedge clock) begin
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            chk("rdata", bus.rdata, mon_e.rdata);
            chk("rillegal", 32'(bus.rillegal), 32'(mon_e.rill));
            chk("willegal", 32'(bus.willegal), 32'(mon_e.will));
            chk("irq", 32'(bus.irq), 32'(mon_e.irq));
            chk("irq_cause", bus.irq_cause, mon_e.cause);
            chk("trap_pc", bus.trap_pc, mon_e.tpc);
            chk("mepc_out", bus.mepc_out, mon_e.mepc);
        end
    end

    initial begin
        tx_t t;
        drive(rd(12'h000));
        m_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("reset irq", 32'(bus.irq), 32'h0);
        chk("reset irq_cause", bus.irq_cause, 32'h0);
        chk("reset mepc_out", bus.mepc_out, 32'h0);
        chk("reset trap_pc", bus.trap_pc, 32'h0);
        reset = 1'b1;

        step(rd(12'h301), 0, 32'h4000_1100, "misa");
        step(rd(12'h301), 4, 32'h0, "misa legal");
        step(rd(12'h7C0), 0, 32'h0, "unimpl rdata");
        step(rd(12'h7C0), 4, 32'h1, "unimpl rillegal");

        step(wr(12'h340, 32'h1234_ABCD));
        step(rd(12'h340), 0, 32'h1234_ABCD, "mscratch");
        step(wr(12'hF14, 32'h5), 3, 32'h1, "mhartid willegal");
        step(rd(12'hF14), 0, 32'h0, "mhartid");

        step(wr(12'h300, 32'h8));
        t = rd(12'h300);
        t.exc = 1'b1; t.cause = 32'h2; t.epc = 32'h100; t.tval = 32'hDEAD;
        step(t);
        step(rd(12'h341), 0, 32'h100, "trap mepc");
        step(rd(12'h342), 0, 32'h2, "trap mcause");
        step(rd(12'h343), 0, 32'hDEAD, "trap mtval");
        step(rd(12'h300), 0, 32'h1880, "trap mstatus");
        t = rd(12'h300);
        t.mret = 1'b1;
        step(t);
        step(rd(12'h300), 0, 32'h1888, "mret mstatus");

        step(wr(12'h305, 32'h1001));
        step(wr(12'h304, 32'h80));
        step(wr(12'h300, 32'h8));
        t = rd(12'h344);
        t.mtip = 1'b1; t.cause = 32'h8000_0007;
        step(t, 5, 32'h1, "irq mti");
        step(t, 1, 32'h8000_0007, "irq_cause mti");
        step(t, 2, 32'h101C, "trap_pc vectored");
        t.wren = 1'b1; t.waddr = 12'h304; t.wdata = 32'h880; t.meip = 1'b1;
        step(t);
        t.wren = 1'b0;
        step(t, 1, 32'h8000_000B, "irq_cause mei");

        step(wr(12'hB00, 32'hFFFF_FFFF));
        step(wr(12'hB80, 32'hFFFF_FFFF));
        step(rd(12'hB00), 0, 32'hFFFF_FFFF, "mcycle before wrap");
        step(rd(12'hB80), 0, 32'h0, "mcycleh wrapped");
        step(rd(12'hB00), 0, 32'h1, "mcycle after wrap");
        t = wr(12'hB02, 32'h55);
        t.inst_ret = 1'b1;
        step(t);
        step(rd(12'hB02), 0, 32'h55, "minstret override");

        step(wr(12'h340, 32'hAAAA));
        t = wr(12'h340, 32'h5555);
        t.exc = 1'b1; t.mret = 1'b1; t.cause = 32'h3; t.epc = 32'h200; t.tval = 32'h1;
        step(t);
        step(rd(12'h340), 0, 32'hAAAA, "prio mscratch");
        step(rd(12'h341), 0, 32'h200, "prio mepc");
        step(rd(12'h300), 0, 32'h1880, "prio mstatus");

        repeat (400) step(rnd());

        bus.raddr = 12'h340;
        #2;
        reset = 1'b0;
        #1;
        chk("midreset mscratch", bus.rdata, 32'h0);
        chk("midreset irq", 32'(bus.irq), 32'h0);
        chk("midreset mepc_out", bus.mepc_out, 32'h0);
        chk("midreset trap_pc", bus.trap_pc, 32'h0);
        m_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        step(rd(12'h300), 0, 32'h1800, "post-reset mstatus");
        step(rd(12'h301), 0, 32'h4000_1100, "post-reset misa");

        repeat (100) step(rnd());

        @(negedge clock);
        chk("queue drained", 32'(q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
